// File: rtl/led_pio_sequencer.sv
// LED pattern sequencer: steps a pattern every PERIOD clocks and pushes each value to an Avalon PIO
// with single-cycle master writes. Define LED_SEQ_IRQ_EN to add the wrap interrupt and CTRL bit3.
module led_pio_sequencer #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned PER_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [WIDTH-1:0] pio_writedata
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPeriod = 2'd1;
  localparam logic [1:0] AddrValue  = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;

  localparam logic [1:0] ModeUp   = 2'd0;
  localparam logic [1:0] ModeDown = 2'd1;
  localparam logic [1:0] ModeRotl = 2'd2;
  localparam logic [1:0] ModePing = 2'd3;

  typedef enum logic [1:0] {StIdle, StWait, StStep, StWrite} state_e;

  state_e           state;
  logic [3:0]       ctrl;
  logic [PER_W-1:0] period;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] cnt_last;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] step_value;
  logic             dir_right;
  logic             step_dir_right;
  logic             step_wrap;
  logic [15:0]      wraps;
  logic             wrap_pending;
  logic             wr_en;
  logic             rd_en;
  logic             ctrl_wr;
  logic             period_wr;
  logic             value_wr;
  logic             status_wr;
  logic             run;
  logic [1:0]       mode;
  logic             one_hot;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign rd_en     = chipselect & ~read_n;
  assign ctrl_wr   = wr_en && (address == AddrCtrl);
  assign period_wr = wr_en && (address == AddrPeriod);
  assign value_wr  = wr_en && (address == AddrValue);
  assign status_wr = wr_en && (address == AddrStatus);

  assign run          = ctrl[0];
  assign mode         = ctrl[2:1];
  assign pio_address  = 2'b00;
  assign unused_wdata = ^writedata;

  // A zero period behaves like a period of one clock.
  assign cnt_last = (period == '0) ? '0 : period - PER_W'(1);

  assign one_hot = (value != '0) && ((value & (value - WIDTH'(1))) == '0);

`ifdef LED_SEQ_IRQ_EN
  assign irq = wrap_pending & ctrl[3];
`else
  assign wrap_pending = 1'b0;
`endif

  always_comb begin
    step_value     = value;
    step_dir_right = dir_right;
    step_wrap      = 1'b0;
    case (mode)
      ModeUp: begin
        step_value = value + WIDTH'(1);
        step_wrap  = &value;
      end
      ModeDown: begin
        step_value = value - WIDTH'(1);
        step_wrap  = (value == '0);
      end
      ModeRotl: begin
        step_value = {value[WIDTH-2:0], value[WIDTH-1]};
        step_wrap  = value[WIDTH-1];
      end
      ModePing: begin
        if (!one_hot) begin
          step_value     = WIDTH'(1);
          step_dir_right = 1'b0;
        end else if (!dir_right) begin
          if (value[WIDTH-1]) begin
            step_value     = value >> 1;
            step_dir_right = 1'b1;
            step_wrap      = 1'b1;
          end else begin
            step_value = value << 1;
          end
        end else begin
          if (value[0]) begin
            step_value     = value << 1;
            step_dir_right = 1'b0;
            step_wrap      = 1'b1;
          end else begin
            step_value = value >> 1;
          end
        end
      end
      default: step_value = value;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      AddrCtrl:   rd_mux = {28'd0, ctrl};
      AddrPeriod: rd_mux = 32'(period);
      AddrValue:  rd_mux = 32'(value);
      AddrStatus: rd_mux = {15'd0, wrap_pending, wraps};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= StIdle;
      ctrl           <= '0;
      period         <= PER_W'(1);
      value          <= '0;
      dir_right      <= 1'b0;
      wraps          <= '0;
      cnt            <= '0;
      readdata       <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
`ifdef LED_SEQ_IRQ_EN
      wrap_pending   <= 1'b0;
`endif
    end else begin
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      if (rd_en) begin
        readdata <= rd_mux;
      end

      case (state)
        StIdle: begin
          cnt <= '0;
          if (run) begin
            state <= StWait;
          end
        end
        StWait: begin
          if (!run) begin
            state <= StIdle;
            cnt   <= '0;
          end else if (period_wr) begin
            cnt <= '0;
          end else if (cnt == cnt_last) begin
            state <= StStep;
            cnt   <= '0;
          end else begin
            cnt <= cnt + PER_W'(1);
          end
        end
        StStep: begin
          // A coincident CPU VALUE write pre-empts the step; its own PIO write goes out instead.
          if (!value_wr) begin
            value          <= step_value;
            dir_right      <= step_dir_right;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_writedata  <= step_value;
            if (step_wrap) begin
              if (wraps != 16'hFFFF) begin
                wraps <= wraps + 16'd1;
              end
`ifdef LED_SEQ_IRQ_EN
              wrap_pending <= 1'b1;
`endif
            end
          end
          cnt   <= '0;
          state <= StWrite;
        end
        StWrite: begin
          state <= run ? StWait : StIdle;
        end
        default: state <= StIdle;
      endcase

      if (ctrl_wr) begin
`ifdef LED_SEQ_IRQ_EN
        ctrl <= writedata[3:0];
`else
        ctrl <= {1'b0, writedata[2:0]};
`endif
      end
      if (period_wr) begin
        period <= writedata[PER_W-1:0];
      end
      if (value_wr) begin
        value          <= writedata[WIDTH-1:0];
        pio_chipselect <= 1'b1;
        pio_write_n    <= 1'b0;
        pio_writedata  <= writedata[WIDTH-1:0];
      end
      if (status_wr) begin
        wraps <= '0;
`ifdef LED_SEQ_IRQ_EN
        wrap_pending <= 1'b0;
`endif
      end
    end
  end

endmodule
